// File: rtl/nibble_serial_add_ctrl_if.sv
// ----------------------------------------------------------------------------
// nibble_serial_add_ctrl_if
//   Handshake and data bundle between a wide-add requester and the
//   nibble-serial add sequencer.
//
//   Operand side : start_valid, start_ready, a, b, cin
//   Result side  : res_valid, res_ready, sum, cout
//   Status       : busy
//   Optional     : ovf (present only when NIBBLE_ADD_OVF_EN is defined)
//
//   Modports
//     master : the requester/consumer (drives operands and res_ready)
//     slave  : the sequencer (drives start_ready, results and status)
//
//   NIBBLES must match the parameter of the attached sequencer.
// ----------------------------------------------------------------------------
interface nibble_serial_add_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef NIBBLE_ADD_OVF_EN
    logic         ovf;
`endif

    modport master (
        output start_valid,
        output a,
        output b,
        output cin,
        output res_ready,
        input  start_ready,
        input  res_valid,
        input  sum,
        input  cout,
`ifdef NIBBLE_ADD_OVF_EN
        input  ovf,
`endif
        input  busy
    );

    modport slave (
        input  start_valid,
        input  a,
        input  b,
        input  cin,
        input  res_ready,
        output start_ready,
        output res_valid,
        output sum,
        output cout,
`ifdef NIBBLE_ADD_OVF_EN
        output ovf,
`endif
        output busy
    );

endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// nibble_serial_add_ctrl
//   Adds two W-bit operands (W = 4*NIBBLES) through one shared 4-bit
//   full_adder, one nibble per clock, least significant nibble first. The
//   carry between nibbles is held in a register. Result {cout,sum} is
//   A + B + cin modulo 2^(W+1).
//
//   Ports
//     clk  : single clock, all state changes on its rising edge
//     rst  : synchronous, active-high reset
//     bus  : nibble_serial_add_ctrl_if.slave
//              start_valid/start_ready : operand handshake (a, b, cin
//                                        sampled on accept)
//              res_valid/res_ready     : result handshake (sum, cout)
//              busy                    : high while RUN or DONE
//              ovf                     : signed overflow (optional)
//
//   Build option
//     NIBBLE_ADD_OVF_EN : when defined, adds the registered two's-complement
//                         overflow flag bus.ovf.
//
//   Parameters
//     NIBBLES : 4-bit slices per operand, 1..16
// ----------------------------------------------------------------------------

// Existing 4-bit ripple adder slice used by the sequencer.
module full_adder (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] z,
    output logic       cout
);
    assign {cout, z} = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
endmodule

// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start_valid; start_ready high
// RUN   | one nibble added per clock, index 0 .. NIBBLES-1
// DONE  | result presented with res_valid until res_ready
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    nibble_serial_add_ctrl_if.slave  bus
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic [IDXW-1:0] idx_q;
    logic [IDXW-1:0] idx_d;
    logic            carry_q;
    logic            cout_q;
    logic            start_ready_q;
    logic            res_valid_q;
    logic            busy_q;
`ifdef NIBBLE_ADD_OVF_EN
    logic            ovf_q;
    logic            ovf_d;
`endif

    // Bit offset of the current nibble.
    logic [IDXW+1:0] base;
    logic [3:0]      fa_x;
    logic [3:0]      fa_y;
    logic [3:0]      fa_z;
    logic            fa_cout;

    assign base  = {idx_q, 2'b00};
    assign idx_d = idx_q + IDXW'(1);

    // Adder is fed from the latched operands in every state; outside RUN
    // its result is simply not used, but it never sees undriven inputs.
    assign fa_x = a_q[base +: 4];
    assign fa_y = b_q[base +: 4];

    full_adder u_full_adder (
        .x    (fa_x),
        .y    (fa_y),
        .cin  (carry_q),
        .z    (fa_z),
        .cout (fa_cout)
    );

`ifdef NIBBLE_ADD_OVF_EN
    // fa_z[3] on the last nibble is the final sum MSB.
    assign ovf_d = (a_q[W-1] == b_q[W-1]) && (fa_z[3] != a_q[W-1]);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            sum_q         <= '0;
            idx_q         <= '0;
            carry_q       <= 1'b0;
            cout_q        <= 1'b0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
`ifdef NIBBLE_ADD_OVF_EN
            ovf_q         <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_q           <= bus.a;
                        b_q           <= bus.b;
                        carry_q       <= bus.cin;
                        idx_q         <= '0;
                        sum_q         <= '0;
                        cout_q        <= 1'b0;
`ifdef NIBBLE_ADD_OVF_EN
                        ovf_q         <= 1'b0;
`endif
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= RUN;
                    end
                end

                RUN: begin
                    sum_q[base +: 4] <= fa_z;
                    carry_q          <= fa_cout;
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= fa_cout;
`ifdef NIBBLE_ADD_OVF_EN
                        ovf_q       <= ovf_d;
`endif
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_d;
                    end
                end

                DONE: begin
                    // sum/cout are not touched here so they stay valid
                    // until the next accept.
                    if (bus.res_ready) begin
                        res_valid_q   <= 1'b0;
                        busy_q        <= 1'b0;
                        start_ready_q <= 1'b1;
                        state_q       <= IDLE;
                    end
                end

                default: begin
                    res_valid_q   <= 1'b0;
                    busy_q        <= 1'b0;
                    start_ready_q <= 1'b1;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.busy        = busy_q;
    assign bus.sum         = sum_q;
    assign bus.cout        = cout_q;
`ifdef NIBBLE_ADD_OVF_EN
    assign bus.ovf         = ovf_q;
`endif

endmodule
